// File: rtl/ssp_cfg_req_init.sv
// Initiator side of the SSP req/ack register-transfer handshake, with a one-deep pending buffer.
// Optional REQ timeout: define SSP_CFG_REQ_TIMEOUT_EN.
module ssp_cfg_req_init #(
  parameter int ADDR_WIDTH     = 6,
  parameter int SYNC_STAGES    = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  SSPCLK,
  input  logic                  SSPRESETn,
  input  logic                  cfg_wr,
  input  logic [ADDR_WIDTH-1:0] cfg_dadr,
  input  logic [ADDR_WIDTH-1:0] cfg_cadr,
  input  logic                  cfg_dlen,
  input  logic                  cfg_dbit,
  input  logic                  ack,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] DADR,
  output logic [ADDR_WIDTH-1:0] CADR,
  output logic                  DLEN,
  output logic                  DBIT,
  output logic                  busy,
  output logic                  done,
  output logic                  pend,
  output logic                  ovr,
  output logic                  tmo
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  ack_sync;
  logic                    ack_s, ack_s_d, ack_rise;
  logic [GW-1:0]           gap_cnt;
  logic [ADDR_WIDTH-1:0]   buf_dadr, buf_cadr;
  logic                    buf_dlen, buf_dbit;
  logic                    req_q, done_q, pend_q, ovr_q;
  logic                    launch_pend, launch_cfg, buf_wr, req_end, tmo_hit;

  always_ff @(posedge SSPCLK) begin
    if (!SSPRESETn) begin
      ack_sync <= '0;
      ack_s_d  <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
      ack_s_d  <= ack_s;
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign ack_rise = ack_s & ~ack_s_d;

`ifdef SSP_CFG_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  // Counter idles at zero outside REQ so it always starts from zero on entry.
  always_ff @(posedge SSPCLK) begin
    if (!SSPRESETn) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state != REQ || req_end) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign tmo_hit = (state == REQ) && !ack_rise && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign tmo     = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  always_ff @(posedge SSPCLK) begin
    if (!SSPRESETn) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_q || cfg_wr)                    state_nxt = REQ;
      REQ:     if (ack_rise || tmo_hit)                 state_nxt = GAP;
      GAP:     if ((gap_cnt == '0) && !ack_s)           state_nxt = IDLE;
      default:                                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    launch_pend = (state == IDLE) && pend_q;
    launch_cfg  = (state == IDLE) && !pend_q && cfg_wr;
    buf_wr      = cfg_wr && ((state != IDLE) || pend_q);
    req_end     = (state == REQ) && (ack_rise || tmo_hit);
  end

  // A write that cannot launch directly lands in the buffer; the buffer is read before it is rewritten.
  always_ff @(posedge SSPCLK) begin
    if (!SSPRESETn) begin
      DADR     <= '0;
      CADR     <= '0;
      DLEN     <= 1'b0;
      DBIT     <= 1'b0;
      buf_dadr <= '0;
      buf_cadr <= '0;
      buf_dlen <= 1'b0;
      buf_dbit <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      if (launch_pend) begin
        DADR <= buf_dadr;
        CADR <= buf_cadr;
        DLEN <= buf_dlen;
        DBIT <= buf_dbit;
      end else if (launch_cfg) begin
        DADR <= cfg_dadr;
        CADR <= cfg_cadr;
        DLEN <= cfg_dlen;
        DBIT <= cfg_dbit;
      end

      if (buf_wr) begin
        buf_dadr <= cfg_dadr;
        buf_cadr <= cfg_cadr;
        buf_dlen <= cfg_dlen;
        buf_dbit <= cfg_dbit;
        pend_q   <= 1'b1;
        if (pend_q) ovr_q <= 1'b1;
      end else if (launch_pend) begin
        pend_q <= 1'b0;
      end

      if (req_end)                          gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

      req_q  <= (state_nxt == REQ);
      done_q <= (state == REQ) && ack_rise;
    end
  end

  assign req  = req_q;
  assign done = done_q;
  assign pend = pend_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_ssp_cfg_req_init.sv
// Bench for ssp_cfg_req_init: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_ssp_cfg_req_init;

  localparam int AW = 6;
  localparam int SS = 2;
  localparam int GC = 4;
  localparam int TC = 16;

  logic          SSPCLK = 1'b0;
  logic          SSPRESETn;
  logic          cfg_wr;
  logic [AW-1:0] cfg_dadr, cfg_cadr;
  logic          cfg_dlen, cfg_dbit;
  logic          ack;
  logic          req, busy, done, pend, ovr, tmo;
  logic [AW-1:0] DADR, CADR;
  logic          DLEN, DBIT;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  bit seen_b = 0;

  ssp_cfg_req_init #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)) dut (
    .SSPCLK(SSPCLK), .SSPRESETn(SSPRESETn), .cfg_wr(cfg_wr), .cfg_dadr(cfg_dadr),
    .cfg_cadr(cfg_cadr), .cfg_dlen(cfg_dlen), .cfg_dbit(cfg_dbit), .ack(ack),
    .req(req), .DADR(DADR), .CADR(CADR), .DLEN(DLEN), .DBIT(DBIT),
    .busy(busy), .done(done), .pend(pend), .ovr(ovr), .tmo(tmo));

  always #5 SSPCLK = ~SSPCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is either requesting or in its post-ack quiet period;
  // timing is tracked with timestamps on a free-running edge count.
  typedef struct packed {logic [AW-1:0] dadr; logic [AW-1:0] cadr; logic dlen; logic dbit;} cfg_t;
  cfg_t m_held = '0, m_buf = '0, incoming;
  bit   m_busy = 0, m_req = 0, m_done = 0, m_pend = 0, m_ovr = 0, m_tmo = 0;
  bit   ack_hist [SS];
  bit   ack_s_prev = 0, ack_s_now, to_buf, pend_before;
  int   cyc = 0, t_rise = 0, t_fall = 0;

  always @(posedge SSPCLK) begin
    cyc++;
    if (!SSPRESETn) begin
      m_held = '0; m_buf = '0;
      m_busy = 0; m_req = 0; m_done = 0; m_pend = 0; m_ovr = 0; m_tmo = 0;
      for (int i = 0; i < SS; i++) ack_hist[i] = 0;
      ack_s_prev = 0;
    end else begin
      ack_s_now   = ack_hist[SS-1];
      incoming    = {cfg_dadr, cfg_cadr, cfg_dlen, cfg_dbit};
      pend_before = m_pend;
      to_buf      = cfg_wr && (m_busy || m_pend);
      m_done      = 0;
      if (!m_busy) begin
        if (m_pend) begin
          m_held = m_buf; m_pend = 0; m_busy = 1; m_req = 1; t_rise = cyc;
        end else if (cfg_wr) begin
          m_held = incoming; m_busy = 1; m_req = 1; t_rise = cyc;
        end
      end else if (m_req) begin
        if (ack_s_now && !ack_s_prev) begin
          m_req = 0; m_done = 1; t_fall = cyc;
        end
`ifdef SSP_CFG_REQ_TIMEOUT_EN
        else if (cyc - t_rise >= TC) begin
          m_req = 0; m_tmo = 1; t_fall = cyc;
        end
`endif
      end else if ((cyc - t_fall >= GC) && !ack_s_now) begin
        m_busy = 0;
      end
      if (to_buf) begin
        if (pend_before) m_ovr = 1;
        m_buf = incoming; m_pend = 1;
      end
      for (int i = SS - 1; i > 0; i--) ack_hist[i] = ack_hist[i-1];
      ack_hist[0] = ack;
      ack_s_prev  = ack_s_now;
    end
  end

  always @(negedge SSPCLK) begin
    if (chk_en) begin
      chk("req", req, m_req);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("pend", pend, m_pend);
      chk("ovr", ovr, m_ovr);
      chk("tmo", tmo, m_tmo);
      chk("DADR", DADR, m_held.dadr);
      chk("CADR", CADR, m_held.cadr);
      chk("DLEN", DLEN, m_held.dlen);
      chk("DBIT", DBIT, m_held.dbit);
      if (DADR == 6'h22) seen_b = 1;
    end
  end

  task automatic write_cfg(input logic [AW-1:0] d, input logic [AW-1:0] c, input logic l, input logic b);
    cfg_wr = 1; cfg_dadr = d; cfg_cadr = c; cfg_dlen = l; cfg_dbit = b;
    @(negedge SSPCLK);
    cfg_wr = 0;
  endtask

  // Pulses ack for 2 cycles and returns how many negedges until done was seen.
  task automatic ack_until_done(output int k);
    k = 0;
    ack = 1;
    while (k < 30) begin
      @(negedge SSPCLK);
      k++;
      if (k == 2) ack = 0;
      if (done) break;
    end
    ack = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || pend) && k < 300) begin
      if (req) begin
        ack = 1;
        repeat (2) @(negedge SSPCLK);
        ack = 0;
        k += 2;
        while (req && k < 300) begin @(negedge SSPCLK); k++; end
      end else begin
        @(negedge SSPCLK); k++;
      end
    end
    chk("drain_idle", {30'd0, busy, pend}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, n, dcnt;
    bit any_req, any_done;
    SSPRESETn = 0; cfg_wr = 0; cfg_dadr = '0; cfg_cadr = '0; cfg_dlen = 0; cfg_dbit = 0; ack = 0;
    @(negedge SSPCLK);
    chk_en = 1;
    chk("rst_req", req, 0);
    chk("rst_DADR", DADR, 0);
    @(negedge SSPCLK);
    SSPRESETn = 1;
    repeat (2) @(negedge SSPCLK);

    // single write
    write_cfg(6'h15, 6'h2A, 1, 0);
    chk("t1_req", req, 1);
    chk("t1_dadr", DADR, 6'h15);
    chk("t1_cadr", CADR, 6'h2A);
    chk("t1_dlen_dbit", {DLEN, DBIT}, 2'b10);
    repeat (5) @(negedge SSPCLK);
    ack_until_done(k);
    chk("t1_done_lat", k, SS + 1);
    chk("t1_req_fall_with_done", req, 0);
    n = 0;
    while (busy && n < 30) begin @(negedge SSPCLK); n++; end
    chk("t1_gap_len", n, GC);

    // pending write
    write_cfg(6'h15, 6'h2A, 1, 0);
    @(negedge SSPCLK);
    write_cfg(6'h01, 6'h03, 0, 1);
    chk("t2_pend", pend, 1);
    chk("t2_dadr_hold", DADR, 6'h15);
    ack_until_done(k);
    chk("t2_dadr_at_done", DADR, 6'h15);
    n = 0;
    while (!req && n < 30) begin @(negedge SSPCLK); n++; end
    chk("t2_b2b_gap", n, GC + 1);
    chk("t2_dadr2", DADR, 6'h01);
    chk("t2_pend_clr", pend, 0);
    drain();

    // overwrite: A, B, C during one transfer
    write_cfg(6'h0A, 6'h05, 0, 0);
    write_cfg(6'h11, 6'h01, 0, 0);
    write_cfg(6'h22, 6'h02, 0, 1);
    write_cfg(6'h33, 6'h0C, 1, 1);
    chk("t3_ovr", ovr, 1);
    ack_until_done(k);
    n = 0;
    while (!req && n < 30) begin @(negedge SSPCLK); n++; end
    chk("t3_dadr_c", DADR, 6'h33);
    chk("t3_cadr_c", CADR, 6'h0C);
    drain();

    // stray ack in IDLE
    any_req = 0; any_done = 0;
    ack = 1;
    repeat (2) @(negedge SSPCLK);
    ack = 0;
    repeat (8) begin
      @(negedge SSPCLK);
      if (req) any_req = 1;
      if (done) any_done = 1;
    end
    chk("t4_stray_req", any_req, 0);
    chk("t4_stray_done", any_done, 0);

    // long ack held 10 cycles in REQ
    write_cfg(6'h07, 6'h08, 0, 1);
    repeat (2) @(negedge SSPCLK);
    k = 0; dcnt = 0;
    ack = 1;
    while (k < 40) begin
      @(negedge SSPCLK);
      k++;
      if (done) dcnt++;
      if (k == 10) ack = 0;
      if (!busy) break;
    end
    ack = 0;
    chk("t4_long_done_cnt", dcnt, 1);
    chk("t4_long_busy_len", k, 13);

    // reset mid-REQ with pending entry
    write_cfg(6'h12, 6'h13, 1, 1);
    @(negedge SSPCLK);
    write_cfg(6'h14, 6'h15, 0, 0);
    chk("t5_pre_req", req, 1);
    chk("t5_pre_pend", pend, 1);
    SSPRESETn = 0;
    @(negedge SSPCLK);
    SSPRESETn = 1;
    chk("t5_req", req, 0);
    chk("t5_pend", pend, 0);
    chk("t5_dadr", DADR, 0);
    chk("t5_cadr", CADR, 0);
    chk("t5_done", done, 0);
    chk("t5_ovr", ovr, 0);
    repeat (3) @(negedge SSPCLK);

    // no ack at all
    write_cfg(6'h3F, 6'h3E, 1, 1);
    k = 0; dcnt = 0;
    while (req && k < 40) begin
      @(negedge SSPCLK);
      k++;
      if (done) dcnt++;
    end
`ifdef SSP_CFG_REQ_TIMEOUT_EN
    chk("t6_tmo_len", k, TC);
    chk("t6_tmo_flag", tmo, 1);
`else
    chk("t6_req_held", req, 1);
    chk("t6_tmo_flag", tmo, 0);
`endif
    chk("t6_no_done", dcnt, 0);
    drain();

    chk("t3_b_never_driven", seen_b, 0);
    repeat (2) @(negedge SSPCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssp_cfg_req_init.md
Name: ssp_cfg_req_init

Overview:
- Initiator end of the req/ack register-transfer handshake. It runs in the SSP clock domain.
- It captures a configuration word (DADR, CADR, DLEN, DBIT), holds it stable on its outputs and raises req.
- It synchronises the returning ack, which comes from the HCLK-domain receiver as a short pulse. On the ack edge it drops req, then enforces a minimum req-low gap before the next transfer.
- A one-deep pending buffer absorbs a configuration write that arrives mid-transfer.

Parameters:
- ADDR_WIDTH, 6, width of DADR/CADR fields.
- SYNC_STAGES, 2, flops in the ack synchroniser chain (minimum 2).
- GAP_CYCLES, 4, minimum SSPCLK cycles req stays low after an ack before re-raising (minimum 1).
- TIMEOUT_CYCLES, 64, REQ-state cycles before abort (used only with the optional feature).

Ports:
- SSPCLK  in  1  clock; all logic on the rising edge.
- SSPRESETn  in  1  reset, synchronous, active-low.
- cfg_wr  in  1  one-cycle strobe; capture the cfg_* inputs.
- cfg_dadr  in  ADDR_WIDTH  data address value.
- cfg_cadr  in  ADDR_WIDTH  CRC/control address value.
- cfg_dlen  in  1  data length select.
- cfg_dbit  in  1  bit-order select.
- ack  in  1  asynchronous ack pulse from the receiver (HCLK domain).
- req  out  1  transfer request to the receiver; driven straight from a flop.
- DADR  out  ADDR_WIDTH  held data address.
- CADR  out  ADDR_WIDTH  held control address.
- DLEN  out  1  held DLEN.
- DBIT  out  1  held DBIT.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a transfer's ack is seen.
- pend  out  1  pending buffer occupied.
- ovr  out  1  sticky: a pending entry was overwritten; cleared only by reset.
- tmo  out  1  sticky timeout flag; exists only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (SSPRESETn=0 at a clock edge), all outputs:
  - req=0, busy=0, done=0, pend=0, ovr=0, tmo=0.
  - DADR/CADR/DLEN/DBIT=0.
  - Synchroniser flops = 0, FSM=IDLE, counters=0.
  - Reset mid-transfer drops req in the next cycle with no done.
- Ack synchroniser: ack passes through SYNC_STAGES flops giving ack_s, plus one edge flop. ack_rise = ack_s & ~ack_s_d.
- IDLE:
  - cfg_wr=1 → load the held outputs from cfg_*, set req=1 and go to REQ in the same edge. req is visible 1 cycle after the strobe.
  - If pend=1 instead: load from the pending buffer, clear pend, set req=1, go to REQ.
- REQ:
  - req=1; held outputs frozen.
  - On ack_rise: req←0, done pulses 1 cycle, gap counter←GAP_CYCLES-1, go to GAP.
- GAP:
  - req=0; held outputs keep their last values.
  - Counter decrements each cycle. At counter=0 and ack_s=0, go to IDLE.
  - If ack_s is still 1, stay in GAP until it returns to 0.
- Writes while busy: cfg_wr in REQ or GAP writes the pending buffer and sets pend=1. Held outputs never change outside IDLE.
- Pending overwrite: if pend is already 1, the buffer is overwritten (last write wins) and ovr←1.
- Simultaneous events:
  - cfg_wr in IDLE with pend=1: the pending entry launches first; the new write replaces the buffer, pend stays 1 and ovr←1.
  - cfg_wr on the same edge as ack_rise: goes to the pending buffer.
- Back-to-back: with a pending entry, the next req rises the cycle after IDLE is entered. The minimum req-low time is GAP_CYCLES+1.
- Stray ack_rise in IDLE or GAP is ignored.

Optional Feature:
- Macro: SSP_CFG_REQ_TIMEOUT_EN.
- Defined:
  - A REQ-state counter starts at 0 on REQ entry.
  - If it reaches TIMEOUT_CYCLES-1 without ack_rise: req←0, tmo←1 (sticky), no done, go to GAP.
  - The pending buffer is preserved.
- Undefined: no counter; REQ waits indefinitely; tmo tied 0.

Test Plan:
- Reset then single write. Stimulus: cfg_wr with dadr=6'h15, cadr=6'h2A, dlen=1, dbit=0; ack pulses 2 cycles, starting 5 cycles after req rises.
  Required: req=1 one cycle after the strobe; outputs equal 15/2A/1/0; done pulses exactly SYNC_STAGES+1 cycles after ack rises; req falls on the same edge as done; busy drops after the GAP_CYCLES-cycle gap.
- Pending write. Stimulus: second cfg_wr (dadr=6'h01) while in REQ.
  Required: pend=1; outputs stay 6'h15 until done; the second req rises exactly GAP_CYCLES+1 cycles after the first falls, with DADR=6'h01.
- Overwrite. Stimulus: three writes (A, B, C) during one transfer.
  Required: ovr=1; the second transfer carries C; B is never driven.
- Stray and long ack. Stimulus: ack pulse in IDLE; ack held high 10 cycles in REQ.
  Required: no req or done from the stray pulse; exactly one done; GAP lasts until ack_s=0.
- Reset mid-REQ. Stimulus: SSPRESETn low for 1 cycle while req=1 with pend=1.
  Required: next cycle req=0, pend=0, held outputs=0, no done.
- With SSP_CFG_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=16. Stimulus: no ack.
  Required: req falls 16 cycles after rising, tmo=1, done never pulses.
